// File: rtl/ysyx_22041752_div_unit_if.sv
// Request/response bundle for ysyx_22041752_div_unit: operand handshake in, result handshake out.
// master = pipeline side (issues operands, consumes results), slave = divider.
interface ysyx_22041752_div_unit_if #(
  parameter int WIDTH = 64
);
  logic             div_valid;
  logic             div_ready;
  logic             div_signed;
  logic             div_word;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output div_valid, div_signed, div_word, dividend, divisor, out_ready,
    input  div_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  div_valid, div_signed, div_word, dividend, divisor, out_ready,
    output div_ready, out_valid, quotient, remainder
  );
endinterface

// File: rtl/ysyx_22041752_div_unit.sv
// Radix-2 restoring divider (signed/unsigned, full/half width) with RISC-V div-by-zero/overflow results.
// Optional macro YSYX_22041752_DIV_EARLY_EN: finish at accept when |divisor| > |dividend|.
module ysyx_22041752_div_unit #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  ysyx_22041752_div_unit_if.slave       div_if
);
  localparam int HALF = WIDTH / 2;
  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(HALF - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  function automatic logic [WIDTH-1:0] sext_half(input logic [WIDTH-1:0] v);
    return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
  endfunction

  function automatic logic [WIDTH-1:0] zext_half(input logic [WIDTH-1:0] v);
    return {{HALF{1'b0}}, v[HALF-1:0]};
  endfunction

  state_t           r_state;
  logic             r_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic [WIDTH-1:0] r_a;        // dividend magnitude, shifted out MSB-first; quotient bits shift in at LSB
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_word;
  logic             r_q_neg;
  logic             r_r_neg;

  logic [WIDTH-1:0] w_a_ext;
  logic [WIDTH-1:0] w_b_ext;
  logic [WIDTH-1:0] w_min;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div_zero;
  logic             w_overflow;
  logic             w_early;
  logic             w_accept;
  logic [WIDTH-1:0] w_res_dividend;

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_a_ext = div_if.dividend;
    w_b_ext = div_if.divisor;
    w_min   = {1'b1, {(WIDTH-1){1'b0}}};
    if (div_if.div_word) begin
      w_a_ext = div_if.div_signed ? sext_half(div_if.dividend) : zext_half(div_if.dividend);
      w_b_ext = div_if.div_signed ? sext_half(div_if.divisor)  : zext_half(div_if.divisor);
      w_min   = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    end
  end

  assign w_a_neg        = div_if.div_signed & w_a_ext[WIDTH-1];
  assign w_b_neg        = div_if.div_signed & w_b_ext[WIDTH-1];
  assign w_a_mag        = w_a_neg ? -w_a_ext : w_a_ext;
  assign w_b_mag        = w_b_neg ? -w_b_ext : w_b_ext;
  assign w_div_zero     = (w_b_ext == '0);
  assign w_overflow     = div_if.div_signed & (w_a_ext == w_min) & (w_b_ext == '1);
  assign w_res_dividend = div_if.div_word ? sext_half(div_if.dividend) : div_if.dividend;
  assign w_accept       = reset & ~flush & (r_state == IDLE) & div_if.div_valid;

`ifdef YSYX_22041752_DIV_EARLY_EN
  assign w_early = ~w_div_zero & (w_b_mag > w_a_mag);
`else
  assign w_early = 1'b0;
`endif

  // One restoring step: the extra top bit of the trial difference is the borrow.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_shift = {r_rem, r_a[WIDTH-1]};
  assign w_trial = {1'b0, w_shift} - {2'b00, r_b};
  assign w_ge    = ~w_trial[WIDTH+1];

  always_comb begin
    w_q_fix = r_q_neg ? -r_a   : r_a;
    w_r_fix = r_r_neg ? -r_rem : r_rem;
    if (r_word) begin
      w_q_fix = sext_half(w_q_fix);
      w_r_fix = sext_half(w_r_fix);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (div_if.div_valid) begin
          r_ready <= 1'b0;
          if (w_div_zero || w_overflow || w_early) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_quotient  <= w_div_zero ? '1 : (w_overflow ? w_res_dividend : '0);
            r_remainder <= w_overflow ? '0 : w_res_dividend;
          end else begin
            r_state <= CALC;
          end
        end
        CALC: if (r_cnt == (r_word ? LAST_WORD : LAST_FULL)) r_state <= FIX;
        FIX: begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
          r_quotient  <= w_q_fix;
          r_remainder <= w_r_fix;
        end
        DONE: if (div_if.out_ready) begin
          r_state     <= IDLE;
          r_ready     <= 1'b1;
          r_out_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; each is loaded at accept before it is ever read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a     <= div_if.div_word ? {w_a_mag[HALF-1:0], {HALF{1'b0}}} : w_a_mag;
      r_b     <= w_b_mag;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_word  <= div_if.div_word;
      r_q_neg <= w_a_neg ^ w_b_neg;
      r_r_neg <= w_a_neg;
    end else if (r_state == CALC) begin
      r_rem <= w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
      r_a   <= {r_a[WIDTH-2:0], w_ge};
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign div_if.div_ready = r_ready;
  assign div_if.out_valid = r_out_valid;
  assign div_if.quotient  = r_quotient;
  assign div_if.remainder = r_remainder;
endmodule

// File: tb/tb_ysyx_22041752_div_unit.sv
// Scoreboard bench for ysyx_22041752_div_unit: stimulus pushes expected results, a monitor checks them.
module tb_ysyx_22041752_div_unit;
  localparam int W = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  ysyx_22041752_div_unit_if #(.WIDTH(W)) ifc ();

  ysyx_22041752_div_unit #(.WIDTH(W), .CNT_W(7)) dut (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .div_if (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_ov  = 1'b0;

`ifdef YSYX_22041752_DIV_EARLY_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 66;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: every rising out_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ifc.out_valid && !prev_ov) begin
      if (sb.size() == 0) begin
        timeout("unexpected out_valid with empty scoreboard");
      end else begin
        e = sb.pop_front();
        check({e.name, " quotient"},  ifc.quotient,  e.q);
        check({e.name, " remainder"}, ifc.remainder, e.r);
        check({e.name, " latency"},   64'(cyc - e.acc), 64'(e.lat));
      end
    end
    prev_ov = ifc.out_valid;
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!ifc.div_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) timeout("wait div_ready");
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sg, input logic wd,
                       input bit push, input logic [63:0] eq, input logic [63:0] er,
                       input int lat, input string name);
    exp_t e;
    wait_ready();
    ifc.div_valid  = 1'b1;
    ifc.dividend   = a;
    ifc.divisor    = b;
    ifc.div_signed = sg;
    ifc.div_word   = wd;
    if (push) begin
      e.q = eq; e.r = er; e.lat = lat; e.acc = cyc; e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
    ifc.div_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || !ifc.div_ready) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) timeout("drain scoreboard");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    ifc.div_valid  = 1'b0;
    ifc.div_signed = 1'b0;
    ifc.div_word   = 1'b0;
    ifc.dividend   = '0;
    ifc.divisor    = '0;
    ifc.out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("reset div_ready", 64'(ifc.div_ready), 64'd1);
    check("reset out_valid", 64'(ifc.out_valid), 64'd0);
    check("reset quotient",  ifc.quotient,  64'd0);
    check("reset remainder", ifc.remainder, 64'd0);

    // Unsigned full-width with backpressure and a pending request held during DONE.
    ifc.out_ready = 1'b0;
    issue(64'd100, 64'd7, 1'b0, 1'b0, 1, 64'd14, 64'd2, 66, "u 100/7");
    t = 0;
    while (!ifc.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout("wait out_valid 100/7");
    ifc.div_valid = 1'b1;
    ifc.dividend  = 64'd5;
    ifc.divisor   = 64'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp div_ready",  64'(ifc.div_ready), 64'd0);
      check("bp out_valid",  64'(ifc.out_valid), 64'd1);
      check("bp quotient",   ifc.quotient,  64'd14);
      check("bp remainder",  ifc.remainder, 64'd2);
    end
    ifc.div_valid = 1'b0;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    check("post handshake out_valid", 64'(ifc.out_valid), 64'd0);
    check("post handshake div_ready", 64'(ifc.div_ready), 64'd1);

    issue(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b0, 1,
          64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 66, "s -100/7");
    drain();
    issue(64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b0, 1,
          64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 66, "s 100/-7");
    drain();
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 1'b0, 1,
          64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 66, "u max/16");
    drain();
    issue(64'h1234, 64'd0, 1'b1, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1, "div by zero");
    drain();
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1,
          64'h8000_0000_0000_0000, 64'd0, 1, "signed overflow");
    drain();
    issue(64'h0000_0001_8000_0000, 64'd1, 1'b0, 1'b1, 1,
          64'hFFFF_FFFF_8000_0000, 64'd0, 34, "uw 0x80000000/1");
    drain();
    issue(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1,
          64'hFFFF_FFFF_8000_0000, 64'd0, 1, "sw overflow");
    drain();
    issue(64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1,
          64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 34, "sw -7/2");
    drain();
    issue(64'h0000_0000_FFFF_FFF0, 64'hABCD_0000_0000_0000, 1'b0, 1'b1, 1,
          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF0, 1, "uw div by zero");
    drain();
    issue(64'd5, 64'd9, 1'b0, 1'b0, 1, 64'd0, 64'd5, EARLY_LAT, "u 5/9");
    drain();
    issue(64'hFFFF_FFFF_FFFF_FFFB, 64'd9, 1'b1, 1'b0, 1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, EARLY_LAT, "s -5/9");
    drain();

    // Flush after 10 iterations: no result may appear.
    issue(64'd1000, 64'd3, 1'b0, 1'b0, 0, 64'd0, 64'd0, 0, "flushed");
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush out_valid", 64'(ifc.out_valid), 64'd0);
    check("flush div_ready", 64'(ifc.div_ready), 64'd1);
    ifc.div_valid = 1'b1;
    ifc.dividend  = 64'd7;
    ifc.divisor   = 64'd2;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    ifc.div_valid = 1'b0;
    check("valid during flush ignored", 64'(ifc.div_ready), 64'd1);
    repeat (80) @(negedge clk);
    issue(64'd20, 64'd3, 1'b0, 1'b0, 1, 64'd6, 64'd2, 66, "u 20/3 after flush");
    drain();

    // Reset pulse mid-CALC: back to IDLE with cleared outputs.
    issue(64'd500, 64'd7, 1'b0, 1'b0, 0, 64'd0, 64'd0, 0, "reset aborted");
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid reset out_valid", 64'(ifc.out_valid), 64'd0);
    check("mid reset div_ready", 64'(ifc.div_ready), 64'd1);
    check("mid reset quotient",  ifc.quotient,  64'd0);
    check("mid reset remainder", ifc.remainder, 64'd0);
    repeat (80) @(negedge clk);
    issue(64'd49, 64'd7, 1'b0, 1'b0, 1, 64'd7, 64'd0, 66, "u 49/7 after reset");
    drain();
    if (sb.size() != 0) timeout("scoreboard not empty at end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_22041752_div_unit.md
Name: ysyx_22041752_div_unit

Overview:
- Parametrised multi-cycle integer divider for the EX stage; successor to the fixed 64-bit divider instance inside the ALU.
- Radix-2 restoring, one quotient bit per cycle.
- Supports signed/unsigned and half-width ("W") mode.
- Uses a valid/ready handshake on both sides, a flush abort, and RISC-V divide-by-zero/overflow semantics.

Parameters:
- WIDTH, 64, operand/result width; must be even and >= 8. Half-width mode operates on WIDTH/2 bits.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- flush  in  1  abort any in-flight operation; pipeline squash.
- div_valid  in  1  request valid.
- div_ready  out  1  unit can accept a request.
- div_signed  in  1  1 = signed (DIV/REM), 0 = unsigned.
- div_word  in  1  1 = half-width op; results sign-extended to WIDTH.
- dividend  in  WIDTH  source 1.
- divisor  in  WIDTH  source 2.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts results.
- quotient  out  WIDTH  quotient.
- remainder  out  WIDTH  remainder.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, div_ready=1, out_valid=0, quotient=0, remainder=0. Any in-flight operation is discarded.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - div_ready=1.
  - Accept when div_valid&div_ready. Latch operands, div_signed and div_word.
  - In word mode, operands are the low WIDTH/2 bits, sign-extended (signed) or zero-extended (unsigned) internally.
  - Form absolute values when signed. Record quotient sign = sign(a)^sign(b) and remainder sign = sign(a).
  - Next state is CALC, except for the special cases below, which go straight to DONE.
- Special cases, decided at accept:
  - divisor==0: quotient = all ones, remainder = dividend.
  - Signed overflow (dividend = most negative value of the active width, divisor = -1): quotient = dividend, remainder = 0.
  - In both cases out_valid rises the cycle after accept.
- CALC:
  - N iterations, N = WIDTH (full) or WIDTH/2 (word).
  - Each cycle: shift partial remainder left 1 and bring in the next dividend bit. Trial-subtract the divisor magnitude. If non-negative, keep the difference and set quotient bit 1; otherwise quotient bit 0.
  - Counter counts from 0 to N-1, then go to FIX.
- FIX (1 cycle): negate quotient/remainder per the recorded signs, apply word-mode sign extension of bit WIDTH/2-1, register outputs, go to DONE.
- DONE:
  - out_valid=1; quotient/remainder held stable.
  - On out_ready: out_valid drops next cycle, go to IDLE.
  - A new request is accepted no earlier than the cycle after the results handshake; div_ready=0 in CALC, FIX and DONE.
- Latency, accept edge to out_valid: N+2 cycles normal (66 for WIDTH=64 full, 34 word); 1 cycle for special cases.
- flush:
  - Takes priority over everything except reset.
  - In any state: next state IDLE and out_valid=0 next cycle.
  - div_valid in the same cycle as flush is not accepted.
  - Result outputs keep their last values; consumers ignore them when out_valid=0.
- Simultaneous out_ready and flush in DONE: flush wins; the result is treated as consumed/discarded.
- Unsigned and signed word results are both sign-extended from bit WIDTH/2-1 (RV64 DIVUW/REMUW semantics).
- No combinational path from div_valid to div_ready. div_ready and out_valid depend on registered state only.

Optional Feature:
- Macro: YSYX_22041752_DIV_EARLY_EN.
- Defined:
  - At accept, if |divisor| > |dividend| (active width, magnitudes, divisor!=0), skip CALC.
  - quotient = 0, remainder = dividend (word mode: sign-extended low half).
  - Go straight to DONE; out_valid rises 1 cycle after accept.
- Undefined: no comparator is built; such cases take the full N+2 latency with identical results.

Test Plan:
- Unsigned full: dividend=100, divisor=7, div_signed=0 -> after 66 cycles out_valid=1, quotient=14, remainder=2; outputs held until out_ready=1, then div_ready=1.
- Signed full: dividend=-100 (0xFFFF_FFFF_FFFF_FF9C), divisor=7 -> quotient=-14 (0x...FFF2), remainder=-2 (0x...FFFE).
- Divide by zero: dividend=0x1234, divisor=0, signed=1 -> out_valid 1 cycle after accept, quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234. Signed overflow: dividend=0x8000_0000_0000_0000, divisor=-1 -> quotient=0x8000_0000_0000_0000, remainder=0.
- Word mode: div_word=1, div_signed=0, dividend=0x0000_0001_8000_0000, divisor=1 -> after 34 cycles quotient=0xFFFF_FFFF_8000_0000, remainder=0. Signed word overflow: dividend low half 0x8000_0000, divisor=0xFFFF_FFFF -> quotient=0xFFFF_FFFF_8000_0000.
- Flush mid-CALC at iteration 10 -> out_valid stays 0, div_ready=1 next cycle. A new request 20/3 then yields quotient=6, remainder=2. Reset (reset=0 for 1 cycle) mid-CALC -> same IDLE state, out_valid=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with div_valid=1 -> div_ready stays 0, results stable. With YSYX_22041752_DIV_EARLY_EN, 5/9 unsigned -> quotient=0, remainder=5 one cycle after accept.
